// File: rtl/table_stream_loader.sv
// Streams NIT words (multi-beat) then linear PFT words into their SRAMs, then kicks address_generator.
// Optional running lane checksum of accepted beats: define LOADER_CHECKSUM_EN.
module table_stream_loader #(
  parameter int NIT_ADDR_WIDTH = 12,
  parameter int NIT_WORD_WIDTH = 330,
  parameter int PFT_ADDR_WIDTH = 10,
  parameter int BEAT_WIDTH     = 128
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      load_start,
  input  logic [NIT_ADDR_WIDTH:0]   n_nit,
  input  logic [PFT_ADDR_WIDTH:0]   n_pft,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BEAT_WIDTH-1:0]     in_data,
  input  logic                      NIT_done,
  output logic                      NIT_write,
  output logic [NIT_ADDR_WIDTH-1:0] NIT_waddr,
  output logic [NIT_WORD_WIDTH-1:0] NIT_din,
  output logic                      write_PFT,
  output logic [PFT_ADDR_WIDTH-1:0] PFT_addr_write,
  output logic [BEAT_WIDTH-1:0]     PFT_din,
  output logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               checksum
);

  localparam int NIT_BEATS  = (NIT_WORD_WIDTH + BEAT_WIDTH - 1) / BEAT_WIDTH;
  localparam int BUF_W      = (NIT_BEATS - 1) * BEAT_WIDTH;
  localparam int TAIL_W     = NIT_WORD_WIDTH - BUF_W;
  localparam int BEAT_CNT_W = $clog2(NIT_BEATS);
  localparam logic [BEAT_CNT_W-1:0]   LAST_BEAT = BEAT_CNT_W'(NIT_BEATS - 1);
  localparam logic [BEAT_CNT_W-1:0]   BEAT_ONE  = BEAT_CNT_W'(1);
  localparam logic [NIT_ADDR_WIDTH:0] NIT_ONE   = (NIT_ADDR_WIDTH + 1)'(1);
  localparam logic [PFT_ADDR_WIDTH:0] PFT_ONE   = (PFT_ADDR_WIDTH + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_NIT, S_LOAD_PFT, S_FLUSH, S_START, S_WAIT
  } state_t;

  state_t                    state_reg;
  logic [NIT_ADDR_WIDTH:0]   n_nit_reg;
  logic [PFT_ADDR_WIDTH:0]   n_pft_reg;
  logic [NIT_ADDR_WIDTH:0]   nit_word_reg;
  logic [PFT_ADDR_WIDTH:0]   pft_beat_reg;
  logic [BEAT_CNT_W-1:0]     beat_reg;
  logic                      ready_reg;
  logic                      nit_write_reg;
  logic [NIT_ADDR_WIDTH-1:0] nit_waddr_reg;
  logic [NIT_WORD_WIDTH-1:0] nit_din_reg;
  logic                      pft_write_reg;
  logic [PFT_ADDR_WIDTH-1:0] pft_addr_reg;
  logic [BEAT_WIDTH-1:0]     pft_din_reg;
  logic                      start_reg;
  logic                      busy_reg;
  logic                      done_reg;
  logic [BUF_W-1:0]          nit_buf;
  logic                      accept;

  assign accept = in_valid & ready_reg;

  // Lower beats of a NIT word wait here until the tail beat arrives.
  genvar gi;
  generate
    for (gi = 0; gi < NIT_BEATS - 1; gi++) begin : g_slot
      logic [BEAT_WIDTH-1:0] slot_reg;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
          slot_reg <= '0;
        else if (state_reg == S_LOAD_NIT && accept && beat_reg == BEAT_CNT_W'(gi))
          slot_reg <= in_data;
      end
      assign nit_buf[gi*BEAT_WIDTH +: BEAT_WIDTH] = slot_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= S_IDLE;
      n_nit_reg     <= '0;
      n_pft_reg     <= '0;
      nit_word_reg  <= '0;
      pft_beat_reg  <= '0;
      beat_reg      <= '0;
      ready_reg     <= 1'b0;
      nit_write_reg <= 1'b0;
      nit_waddr_reg <= '0;
      nit_din_reg   <= '0;
      pft_write_reg <= 1'b0;
      pft_addr_reg  <= '0;
      pft_din_reg   <= '0;
      start_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      nit_write_reg <= 1'b0;
      pft_write_reg <= 1'b0;
      start_reg     <= 1'b0;
      done_reg      <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (load_start) begin
            n_nit_reg    <= n_nit;
            n_pft_reg    <= n_pft;
            nit_word_reg <= '0;
            pft_beat_reg <= '0;
            beat_reg     <= '0;
            busy_reg     <= 1'b1;
            if (n_nit != '0) begin
              state_reg <= S_LOAD_NIT;
              ready_reg <= 1'b1;
            end else if (n_pft != '0) begin
              state_reg <= S_LOAD_PFT;
              ready_reg <= 1'b1;
            end else begin
              state_reg <= S_FLUSH;
            end
          end
        end
        S_LOAD_NIT: begin
          if (accept) begin
            if (beat_reg == LAST_BEAT) begin
              beat_reg      <= '0;
              nit_write_reg <= 1'b1;
              nit_waddr_reg <= nit_word_reg[NIT_ADDR_WIDTH-1:0];
              nit_din_reg   <= {in_data[TAIL_W-1:0], nit_buf};
              nit_word_reg  <= nit_word_reg + NIT_ONE;
              // Ready stays high into PFT so the next beat is taken as PFT data.
              if (nit_word_reg + NIT_ONE == n_nit_reg) begin
                if (n_pft_reg != '0) begin
                  state_reg <= S_LOAD_PFT;
                end else begin
                  state_reg <= S_FLUSH;
                  ready_reg <= 1'b0;
                end
              end
            end else begin
              beat_reg <= beat_reg + BEAT_ONE;
            end
          end
        end
        S_LOAD_PFT: begin
          if (accept) begin
            pft_write_reg <= 1'b1;
            pft_addr_reg  <= pft_beat_reg[PFT_ADDR_WIDTH-1:0];
            pft_din_reg   <= in_data;
            pft_beat_reg  <= pft_beat_reg + PFT_ONE;
            if (pft_beat_reg + PFT_ONE == n_pft_reg) begin
              state_reg <= S_FLUSH;
              ready_reg <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          state_reg <= S_START;
          start_reg <= 1'b1;
        end
        S_START: begin
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (NIT_done) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready       = ready_reg;
  assign NIT_write      = nit_write_reg;
  assign NIT_waddr      = nit_waddr_reg;
  assign NIT_din        = nit_din_reg;
  assign write_PFT      = pft_write_reg;
  assign PFT_addr_write = pft_addr_reg;
  assign PFT_din        = pft_din_reg;
  assign start          = start_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;

`ifdef LOADER_CHECKSUM_EN
  localparam int LANES = BEAT_WIDTH / 32;
  logic [31:0] lane_sum;
  logic [31:0] checksum_reg;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++)
      lane_sum = lane_sum + in_data[i*32 +: 32];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      checksum_reg <= '0;
    else if (state_reg == S_IDLE && load_start)
      checksum_reg <= '0;
    else if (accept)
      checksum_reg <= checksum_reg + lane_sum;
  end

  assign checksum = checksum_reg;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_table_stream_loader.sv
// Directed bench for table_stream_loader: a write-plan model derived from the beat list is checked
// against every SRAM write, plus literal checks on timing, reset state and checksum.
module tb_table_stream_loader;
  localparam int NAW = 12;
  localparam int NWW = 330;
  localparam int PAW = 10;
  localparam int BW  = 128;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           load_start = 1'b0;
  logic [NAW:0]   n_nit = '0;
  logic [PAW:0]   n_pft = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [BW-1:0]  in_data = '0;
  logic           NIT_done = 1'b0;
  logic           NIT_write;
  logic [NAW-1:0] NIT_waddr;
  logic [NWW-1:0] NIT_din;
  logic           write_PFT;
  logic [PAW-1:0] PFT_addr_write;
  logic [BW-1:0]  PFT_din;
  logic           start;
  logic           busy;
  logic           done;
  logic [31:0]    checksum;

  table_stream_loader #(
    .NIT_ADDR_WIDTH(NAW), .NIT_WORD_WIDTH(NWW), .PFT_ADDR_WIDTH(PAW), .BEAT_WIDTH(BW)
  ) dut (
    .clk(clk), .rstn(rstn), .load_start(load_start), .n_nit(n_nit), .n_pft(n_pft),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .NIT_done(NIT_done),
    .NIT_write(NIT_write), .NIT_waddr(NIT_waddr), .NIT_din(NIT_din),
    .write_PFT(write_PFT), .PFT_addr_write(PFT_addr_write), .PFT_din(PFT_din),
    .start(start), .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int errors = 0;
  int checks = 0;

  logic [BW-1:0]  beats[$];
  logic [NAW-1:0] exp_nit_addr[$];
  logic [NWW-1:0] exp_nit_data[$];
  logic [PAW-1:0] exp_pft_addr[$];
  logic [BW-1:0]  exp_pft_data[$];

  int nit_writes = 0, pft_writes = 0, start_count = 0;
  int start_cycle = 0, last_accept_cycle = 0, load_cycle = 0;
  logic [NWW-1:0] last_nit_din = '0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the first 3*nn beats form NIT words (tail beat truncated), the rest are PFT words.
  task automatic plan(input int nn, input int np);
    logic [BW-1:0] b2;
    for (int w = 0; w < nn; w++) begin
      b2 = beats[3*w+2];
      exp_nit_addr.push_back(NAW'(w));
      exp_nit_data.push_back({b2[73:0], beats[3*w+1], beats[3*w]});
    end
    for (int p = 0; p < np; p++) begin
      exp_pft_addr.push_back(PAW'(p));
      exp_pft_data.push_back(beats[3*nn+p]);
    end
  endtask

  function automatic logic [BW-1:0] rand_beat();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Monitor: every write must match the model's next planned write and follow an acceptance.
  initial begin : monitor
    logic prev_accept;
    logic [NAW-1:0] ea;
    logic [NWW-1:0] ed;
    logic [PAW-1:0] pa;
    logic [BW-1:0]  pd;
    prev_accept = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (NIT_write) begin
          nit_writes++;
          last_nit_din = NIT_din;
          $display("nit write addr=%0d", NIT_waddr);
          if (exp_nit_addr.size() == 0) begin
            check("nit_write_unexpected", {511'b0, NIT_write}, 512'b0);
          end else begin
            ea = exp_nit_addr.pop_front();
            ed = exp_nit_data.pop_front();
            check("nit_waddr", NIT_waddr, ea);
            check("nit_din", NIT_din, ed);
            check("nit_write_after_accept", {511'b0, prev_accept}, 512'd1);
          end
        end
        if (write_PFT) begin
          pft_writes++;
          $display("pft write addr=%0d", PFT_addr_write);
          if (exp_pft_addr.size() == 0) begin
            check("pft_write_unexpected", {511'b0, write_PFT}, 512'b0);
          end else begin
            pa = exp_pft_addr.pop_front();
            pd = exp_pft_data.pop_front();
            check("pft_addr", PFT_addr_write, pa);
            check("pft_din", PFT_din, pd);
            check("pft_write_after_accept", {511'b0, prev_accept}, 512'd1);
          end
        end
        if (start) begin
          start_count++;
          start_cycle = cycle;
        end
        prev_accept = in_valid && in_ready;
        if (prev_accept) last_accept_cycle = cycle;
      end else begin
        prev_accept = 1'b0;
      end
    end
  end

  task automatic start_load(input int nn, input int np);
    nit_writes = 0;
    pft_writes = 0;
    start_count = 0;
    load_start = 1'b1;
    n_nit = (NAW+1)'(nn);
    n_pft = (PAW+1)'(np);
    load_cycle = cycle;
    @(posedge clk); #1;
    load_start = 1'b0;
    n_nit = '1;
    n_pft = '1;
    $display("load n_nit=%0d n_pft=%0d", nn, np);
  endtask

  task automatic send_stream(input int first, input int last_excl, input bit gaps);
    bit acc;
    for (int i = first; i < last_excl; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data = rand_beat();
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data = beats[i];
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
      end
      check("beat_accepted", {511'b0, acc}, 512'd1);
    end
    in_valid = 1'b0;
    in_data = rand_beat();
  endtask

  task automatic wait_start();
    for (int t = 0; t < 100; t++) begin
      if (start_count >= 1) break;
      @(posedge clk);
    end
    #1;
    check("start_seen", start_count, 1);
  endtask

  task automatic pulse_done();
    NIT_done = 1'b1;
    @(posedge clk); #1;
    NIT_done = 1'b0;
    @(negedge clk);
    check("done_pulse", {511'b0, done}, 512'd1);
    check("busy_after_done", {511'b0, busy}, 512'b0);
    @(negedge clk);
    check("done_one_cycle", {511'b0, done}, 512'b0);
    @(posedge clk); #1;
    check("start_once", start_count, 1);
    check("nit_plan_drained", exp_nit_addr.size(), 0);
    check("pft_plan_drained", exp_pft_addr.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {480'b0, in_ready, NIT_write, write_PFT, start, busy, done, NIT_waddr, PFT_addr_write, checksum[31:28]}, 512'b0);
    check({tag, "_data"}, {54'b0, NIT_din, PFT_din}, 512'b0);
    check({tag, "_sum"}, checksum, 512'b0);
  endtask

  localparam logic [NWW-1:0] LIT_WORD =
    {74'h3FFFFFFFFFFFFFFFFFF, 128'h22222222222222222222222222222222, 128'h11111111111111111111111111111111};

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    @(posedge clk); #1;
    rstn = 1'b1;

    // 1: two NIT words then three PFT words, continuous valid
    beats.delete();
    for (int i = 0; i < 9; i++) beats.push_back(rand_beat() | {1'b1, 127'b0});
    plan(2, 3);
    start_load(2, 3);
    send_stream(0, 9, 1'b0);
    wait_start();
    check("start_after_last_beat", start_cycle - last_accept_cycle, 2);
    check("nit_writes_t1", nit_writes, 2);
    check("pft_writes_t1", pft_writes, 3);
    repeat (4) @(posedge clk);
    #1;
    check("busy_in_wait", {511'b0, busy}, 512'd1);
    pulse_done();

    // 2: single NIT word with bubbles between beats, literal word
    beats.delete();
    beats.push_back({4{32'h11111111}});
    beats.push_back({4{32'h22222222}});
    beats.push_back({4{32'hFFFFFFFF}});
    plan(1, 0);
    start_load(1, 0);
    send_stream(0, 2, 1'b1);
    check("no_nit_write_before_tail", nit_writes, 0);
    send_stream(2, 3, 1'b1);
    wait_start();
    check("nit_din_literal", last_nit_din, LIT_WORD);
    check("nit_writes_t2", nit_writes, 1);
    pulse_done();

    // 3: reset after one NIT beat, then a clean reload
    beats.delete();
    beats.push_back(rand_beat());
    start_load(1, 0);
    send_stream(0, 1, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    beats.delete();
    for (int i = 0; i < 3; i++) beats.push_back(rand_beat());
    plan(1, 0);
    start_load(1, 0);
    send_stream(0, 3, 1'b0);
    wait_start();
    check("nit_writes_t3", nit_writes, 1);
    pulse_done();

    // 4: empty load goes straight to start
    start_load(0, 0);
    wait_start();
    check("empty_start_latency", start_cycle - load_cycle, 2);
    check("empty_no_writes", nit_writes + pft_writes, 0);
    pulse_done();

    // 5: load_start ignored during LOAD_PFT and WAIT
    beats.delete();
    for (int i = 0; i < 5; i++) beats.push_back(rand_beat());
    plan(1, 2);
    start_load(1, 2);
    send_stream(0, 4, 1'b0);
    load_start = 1'b1;
    n_nit = (NAW+1)'(7);
    n_pft = (PAW+1)'(9);
    @(posedge clk); #1;
    load_start = 1'b0;
    send_stream(4, 5, 1'b0);
    wait_start();
    load_start = 1'b1;
    n_nit = '0;
    n_pft = '0;
    @(posedge clk); #1;
    load_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("wait_ignores_load", {511'b0, busy}, 512'd1);
    check("nit_writes_t5", nit_writes, 1);
    check("pft_writes_t5", pft_writes, 2);
    pulse_done();
    beats.delete();
    beats.push_back(rand_beat());
    plan(0, 1);
    start_load(0, 1);
    send_stream(0, 1, 1'b0);
    wait_start();
    check("reload_pft_writes", pft_writes, 1);
    pulse_done();

    // 6: checksum of a single PFT beat
    beats.delete();
    beats.push_back({32'h4, 32'h3, 32'h2, 32'h1});
    plan(0, 1);
    start_load(0, 1);
    send_stream(0, 1, 1'b0);
    wait_start();
`ifdef LOADER_CHECKSUM_EN
    check("checksum", checksum, 10);
`else
    check("checksum", checksum, 0);
`endif
    pulse_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/table_stream_loader.md
Name: table_stream_loader

Overview:
- Streaming writer that fills the NIT and PFT SRAMs from one external valid/ready beat stream, then pulses start to address_generator.
- NIT load runs first, then PFT load, then start. The block waits for NIT_done before it accepts another load.
- It is the write side of the same tables that address_generator reads. It replaces hand-driven table loading.
- PFT write addresses are linear; microaddr_generator maps them to bank and microaddress outside this block.

Parameters:
- NIT_ADDR_WIDTH, 12, NIT word address width
- NIT_WORD_WIDTH, 330, NIT word width ((32+1)*10)
- PFT_ADDR_WIDTH, 10, linear PFT write address width
- BEAT_WIDTH, 128, stream beat width; equals PFT word width (8*16)
- NIT_BEATS, derived ceil(NIT_WORD_WIDTH/BEAT_WIDTH) = 3, beats per NIT word

Ports:
- clk  in  1  clock
- rstn  in  1  reset. Asynchronous, active-low.
- load_start  in  1  one-cycle request; sampled only in IDLE
- n_nit  in  NIT_ADDR_WIDTH+1  number of NIT words; captured at load_start
- n_pft  in  PFT_ADDR_WIDTH+1  number of PFT words; captured at load_start
- in_valid  in  1  beat valid
- in_ready  out  1  beat ready
- in_data  in  BEAT_WIDTH  beat payload
- NIT_done  in  1  from address_generator
- NIT_write  out  1  NIT SRAM write enable
- NIT_waddr  out  NIT_ADDR_WIDTH  NIT write address
- NIT_din  out  NIT_WORD_WIDTH  NIT write data
- write_PFT  out  1  PFT write enable, before microaddr mapping
- PFT_addr_write  out  PFT_ADDR_WIDTH  linear PFT write address
- PFT_din  out  BEAT_WIDTH  PFT write data
- start  out  1  one-cycle kick to address_generator
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when NIT_done is seen in WAIT
- checksum  out  32  see Optional Feature

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0, all counters are 0, and any partial NIT word is discarded.
- States and transitions:
  - IDLE: on load_start, capture n_nit and n_pft. Go to LOAD_NIT if n_nit!=0, else LOAD_PFT if n_pft!=0, else FLUSH.
  - LOAD_NIT: in_ready=1. Beat accepted when in_valid & in_ready.
    - Beat k of a word (k=0..2) fills bits [128k +: 128]. Beat 2 contributes only its low 74 bits; its upper 54 bits are ignored.
    - On acceptance of beat 2, NIT_write=1 in the next cycle, with NIT_din = assembled word and NIT_waddr = word index (0,1,2,...).
    - After word n_nit-1 is accepted, go to LOAD_PFT if n_pft!=0, else FLUSH.
  - LOAD_PFT: in_ready=1. Each accepted beat gives write_PFT=1 in the next cycle, with PFT_din = beat and PFT_addr_write = beat index. After beat n_pft-1, go to FLUSH.
  - FLUSH: in_ready=0. One cycle, so the last SRAM write completes. Go to START.
  - START: start=1 for exactly one cycle. Go to WAIT.
  - WAIT: when NIT_done=1, done=1 for one cycle and go to IDLE.
- Write timing:
  - Write outputs are registered; the enables are 0 in every cycle without a new write.
  - Data and address outputs hold their last value between writes.
- Stalls: in_valid=0 stalls with no side effects, and partial NIT words are retained across bubbles.
- Ignored inputs:
  - load_start outside IDLE is ignored.
  - in_data is ignored whenever in_ready=0.
- Timing example: last PFT beat accepted in cycle t → write_PFT in t+1 (FLUSH) → start in t+2.
- Mode switch: the cycle that accepts the final NIT beat never also accepts a PFT beat. in_ready stays 1 and the next beat is treated as PFT.
- Counters compare against the captured counts only. n_nit and n_pft may change freely after capture.
- Reset mid-operation clears everything; NIT and PFT SRAM contents are not touched.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: checksum is the 32-bit running sum, mod 2^32, of every accepted beat split into four 32-bit lanes. It is cleared at load_start acceptance and stable from FLUSH onward.
- Undefined: checksum is constant 0 and no adder logic is built.

Test Plan:
- n_nit=2, n_pft=3, continuous valid, 9 beats → NIT_write at addr 0 then 1, each word built from 3 beats with the upper 54 bits dropped; write_PFT at addr 0,1,2; start exactly 2 cycles after last beat acceptance; NIT_done 5 cycles later → done pulse, busy=0.
- n_nit=1 with in_valid low on alternate cycles → no NIT_write until beat 3 is accepted; NIT_din equals {beat2[73:0], beat1, beat0}.
- n_nit=0, n_pft=0 → IDLE→FLUSH→START; start two cycles after load_start; no write enables asserted.
- rstn low after 1 NIT beat, then a new load with n_nit=1 → all outputs 0 during reset; the first NIT_write after reload is at addr 0 with data only from new beats.
- load_start pulsed during LOAD_PFT and WAIT → ignored; counts unchanged; a second load after done proceeds normally.
- With LOADER_CHECKSUM_EN: one PFT beat 0x00000004_00000003_00000002_00000001 → checksum=10. Without the macro → checksum=0.
